// File: rtl/intr_ctrl.sv
// Nested, priority-ordered interrupt controller feeding the
// CPU return-address stack (push on entry, pop on return).
module intr_ctrl #(
    parameter int          NSRC     = 4,
    parameter logic [9:0]  VEC_BASE = 10'h3E0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq,
    input  logic [9:0]      pc,
    input  logic            ei,
    input  logic            di,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_din,
    input  logic            reti,
    input  logic            stk_busy,
    output logic            push,
    output logic            pop,
    output logic            s_intr,
    output logic [9:0]      dato,
    output logic            intr_take,
    output logic [9:0]      vector,
    output logic [NSRC-1:0] isr,
    output logic [NSRC-1:0] pending
);

    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int LW = $clog2(NSRC + 1);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   sel_q;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] isr_q, isr_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic            gie_q, gie_d;

    logic [NSRC-1:0] elig;
    logic [LW-1:0]   cand;
    logic            cand_vld;
    logic [LW-1:0]   lvl;
    logic            take;
    logic            ret_ok;
    logic [NSRC-1:0] sel_oh;

    // Highest-priority eligible request (lowest index); NSRC if none.
    always_comb begin
        elig     = pending_q & mask_q;
        cand     = LW'(NSRC);
        cand_vld = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                cand     = LW'(i);
                cand_vld = 1'b1;
            end
        end
    end

    // Current in-service level (lowest index); NSRC when nothing active.
    always_comb begin
        lvl = LW'(NSRC);
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (isr_q[i]) lvl = LW'(i);
        end
    end

    assign take = (state_q == IDLE) & gie_q & cand_vld & (cand < lvl)
                & ~reti & ~stk_busy;
    assign ret_ok = (state_q == IDLE) & reti & (|isr_q);
    assign sel_oh = NSRC'(1) << sel_q;

    // Next-state for request latch, in-service bits, mask and enable.
    always_comb begin
        pending_d = pending_q;
        isr_d     = isr_q;
        mask_d    = mask_q;
        gie_d     = gie_q;
        if (state_q == ACK) begin
            pending_d = pending_d & ~sel_oh;
            isr_d     = isr_q | sel_oh;
        end else if (ret_ok) begin
            isr_d = isr_q & (isr_q - NSRC'(1));
        end
        // a fresh edge beats the clear from ACK
        pending_d = pending_d | (irq & ~irq_q);
        if (mask_we) mask_d = mask_din;
        if (di)      gie_d  = 1'b0;
        else if (ei) gie_d  = 1'b1;
    end

    // Entry FSM and all controller state; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            irq_q     <= '0;
            pending_q <= '0;
            isr_q     <= '0;
            mask_q    <= '0;
            gie_q     <= 1'b0;
        end else begin
            irq_q     <= irq;
            pending_q <= pending_d;
            isr_q     <= isr_d;
            mask_q    <= mask_d;
            gie_q     <= gie_d;
            unique case (state_q)
                IDLE: begin
                    if (take) begin
                        state_q <= ACK;
                        sel_q   <= SW'(cand);
                    end
                end
                ACK: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes are suppressed while reset is low so no stack access
    // happens at a resetting edge.
    assign intr_take = (state_q == ACK) & reset;
    assign push      = (state_q == ACK) & reset;
    assign pop       = ret_ok & reset;
    assign s_intr    = ret_ok & reset;
    assign dato      = pc;
    assign vector    = VEC_BASE + 10'({sel_q, 2'b00});
    assign isr       = isr_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: stack events are queued by the
// stimulus and matched by a negedge monitor.
module tb_intr_ctrl;

    logic       clk = 0;
    logic       reset;
    logic [3:0] irq;
    logic [9:0] pc;
    logic       ei, di, mask_we;
    logic [3:0] mask_din;
    logic       reti, stk_busy;
    logic       push, pop, s_intr, intr_take;
    logic [9:0] dato, vector;
    logic [3:0] isr, pending;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       push;
        logic       pop;
        logic [9:0] dato;
        logic [9:0] vector;
    } ev_t;

    ev_t q[$];

    intr_ctrl #(.NSRC(4), .VEC_BASE(10'h3E0)) dut (
        .clk(clk), .reset(reset), .irq(irq), .pc(pc),
        .ei(ei), .di(di), .mask_we(mask_we), .mask_din(mask_din),
        .reti(reti), .stk_busy(stk_busy),
        .push(push), .pop(pop), .s_intr(s_intr), .dato(dato),
        .intr_take(intr_take), .vector(vector),
        .isr(isr), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [9:0] d, input logic [9:0] v);
        ev_t e;
        e.push = 1'b1; e.pop = 1'b0; e.dato = d; e.vector = v;
        q.push_back(e);
    endtask

    task automatic exp_pop();
        ev_t e;
        e.push = 1'b0; e.pop = 1'b1; e.dato = '0; e.vector = '0;
        q.push_back(e);
    endtask

    // Monitor: any stack strobe must match the head of the queue.
    always @(negedge clk) begin
        if (push | pop | s_intr | intr_take) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event push=%b pop=%b s_intr=%b take=%b",
                         push, pop, s_intr, intr_take);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("ev_push", 32'(push), 32'(e.push));
                chk("ev_take", 32'(intr_take), 32'(e.push));
                chk("ev_pop", 32'(pop), 32'(e.pop));
                chk("ev_s_intr", 32'(s_intr), 32'(e.pop));
                if (e.push) begin
                    chk("ev_dato", 32'(dato), 32'(e.dato));
                    chk("ev_vector", 32'(vector), 32'(e.vector));
                end
            end
        end
    end

    initial begin
        reset = 0; irq = 0; pc = 10'h000; ei = 0; di = 0;
        mask_we = 0; mask_din = 0; reti = 0; stk_busy = 0;
        tick();
        tick();
        chk("rst_push", 32'(push), 0);
        chk("rst_pop", 32'(pop), 0);
        chk("rst_vector", 32'(vector), 32'h3E0);
        chk("rst_isr", 32'(isr), 0);
        chk("rst_pending", 32'(pending), 0);

        // enable everything
        reset = 1; mask_we = 1; mask_din = 4'b1111; ei = 1;
        tick();
        mask_we = 0; ei = 0;

        // source 2 entry
        pc = 10'h050; irq = 4'b0100;
        tick();
        chk("t1_pending", 32'(pending), 32'h4);
        exp_push(10'h050, 10'h3E8);
        irq = 0;
        tick();
        tick();
        chk("t1_isr", 32'(isr), 32'h4);
        chk("t1_pending_clr", 32'(pending), 0);

        // lower priority 3 must wait, 0 preempts
        pc = 10'h123; irq = 4'b1000;
        tick();
        irq = 0;
        tick();
        tick();
        tick();
        chk("t2_pend3", 32'(pending), 32'h8);
        chk("t2_isr", 32'(isr), 32'h4);
        irq = 4'b0001;
        tick();
        chk("t2_pend", 32'(pending), 32'h9);
        exp_push(10'h123, 10'h3E0);
        irq = 0;
        tick();
        tick();
        chk("t2_isr_nest", 32'(isr), 32'h5);
        chk("t2_pend_after", 32'(pending), 32'h8);

        // two returns, then held source 3 is taken
        pc = 10'h200; reti = 1;
        exp_pop();
        exp_pop();
        exp_push(10'h200, 10'h3EC);
        tick();
        chk("t3_isr1", 32'(isr), 32'h4);
        tick();
        chk("t3_isr0", 32'(isr), 32'h0);
        reti = 0;
        tick();
        tick();
        chk("t3_isr3", 32'(isr), 32'h8);
        chk("t3_pend", 32'(pending), 32'h0);
        reti = 1;
        exp_pop();
        tick();
        reti = 0;
        chk("t3_isr_clr", 32'(isr), 32'h0);

        // gie off, mask off, stk_busy each block source 1
        di = 1;
        tick();
        di = 0;
        pc = 10'h0AA; irq = 4'b0010;
        tick();
        irq = 0;
        tick();
        tick();
        chk("t4_pend_gie", 32'(pending), 32'h2);
        mask_we = 1; mask_din = 4'b1101; ei = 1;
        tick();
        mask_we = 0; ei = 0;
        tick();
        tick();
        chk("t4_pend_mask", 32'(pending), 32'h2);
        stk_busy = 1; mask_we = 1; mask_din = 4'b1111;
        tick();
        mask_we = 0;
        tick();
        tick();
        chk("t4_pend_busy", 32'(pending), 32'h2);
        chk("t4_isr_busy", 32'(isr), 32'h0);
        stk_busy = 0;
        exp_push(10'h0AA, 10'h3E4);
        tick();
        tick();
        tick();
        tick();
        chk("t4_isr", 32'(isr), 32'h2);
        reti = 1;
        exp_pop();
        tick();
        reti = 0;
        chk("t4_isr_clr", 32'(isr), 32'h0);

        // reti with nothing in service
        reti = 1;
        #1;
        chk("t5_pop_idle", 32'(pop), 0);
        tick();
        reti = 0;
        chk("t5_isr", 32'(isr), 0);

        // simultaneous 0 and 1
        pc = 10'h111; irq = 4'b0011;
        tick();
        chk("t5_pend", 32'(pending), 32'h3);
        exp_push(10'h111, 10'h3E0);
        irq = 0;
        tick();
        tick();
        chk("t5_isr0", 32'(isr), 32'h1);
        chk("t5_pend1", 32'(pending), 32'h2);
        reti = 1;
        exp_pop();
        exp_push(10'h111, 10'h3E4);
        tick();
        reti = 0;
        tick();
        tick();
        chk("t5_isr1", 32'(isr), 32'h2);
        reti = 1;
        exp_pop();
        tick();
        reti = 0;

        // reset in the ACK cycle
        pc = 10'h077; irq = 4'b0100;
        tick();
        irq = 0;
        tick();
        reset = 0;
        #1;
        chk("t6_push_rst", 32'(push), 0);
        chk("t6_take_rst", 32'(intr_take), 0);
        tick();
        reset = 1;
        chk("t6_isr", 32'(isr), 0);
        chk("t6_pend", 32'(pending), 0);
        chk("t6_vector", 32'(vector), 32'h3E0);
        irq = 4'b0100;
        tick();
        irq = 0;
        tick();
        tick();
        chk("t6_pend_hold", 32'(pending), 32'h4);
        chk("t6_isr_hold", 32'(isr), 0);

        tick();
        chk("q_empty", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller sitting directly upstream of the CPU return-address stack. It latches rising edges on NSRC request lines, selects the highest-priority eligible request, and redirects the CPU to a vector. On entry it drives the stack push with the interrupted PC; on return-from-interrupt it drives the stack pop with `s_intr` asserted, so the stack returns the exact interrupted address. It tracks nested in-service levels so that only higher-priority requests can preempt.

## Interface
- NSRC, 4, number of interrupt sources (2..8); index 0 is the highest priority.
- VEC_BASE, 10'h3E0, base of the vector table; vector for source i = VEC_BASE + 4*i (10-bit, wraps mod 1024).
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low: 0 at a rising clk edge resets the block.
- irq  in  NSRC  interrupt request levels; rising edge = request.
- pc  in  10  address of the instruction the CPU would execute this cycle.
- ei  in  1  set global enable (gie).
- di  in  1  clear global enable; wins over ei.
- mask_we  in  1  write mask register.
- mask_din  in  NSRC  mask value; bit=1 enables that source.
- reti  in  1  return-from-interrupt decoded this cycle.
- stk_busy  in  1  CPU's own call/ret uses the stack this cycle.
- push  out  1  stack push strobe.
- pop  out  1  stack pop strobe.
- s_intr  out  1  stack interrupt-return select.
- dato  out  10  return address to stack (= pc, combinational).
- intr_take  out  1  PC mux select: load vector this cycle.
- vector  out  10  target address, valid while intr_take=1.
- isr  out  NSRC  in-service bits.
- pending  out  NSRC  latched requests.

## Operation
- Reset (reset=0 at edge): irq_q, pending, isr, mask = 0; gie = 0; state = IDLE; sel = 0. Therefore push, pop, s_intr, intr_take = 0 and vector = VEC_BASE.
- Edge detect: irq_q <= irq each cycle. pending[i] is set at the edge where irq[i]=1 and irq_q[i]=0. The set wins over a clear in the same cycle.
- cand = lowest index i with pending[i] & mask[i]. lvl = lowest index set in isr, or NSRC if isr is 0.
- FSM IDLE -> ACK when all hold: gie=1, cand exists, cand < lvl, reti=0, stk_busy=0. On that transition, sel <= cand.
- ACK (exactly one cycle): intr_take=1, push=1, vector=VEC_BASE+4*sel, dato=pc. At the edge leaving ACK: pending[sel] cleared, isr[sel] set, state -> IDLE. The reti input is ignored in ACK because the redirected instruction is squashed.
- Return (IDLE only): pop = s_intr = reti & (isr≠0), combinational. At the edge, the lowest-index set isr bit is cleared. reti with isr=0 has no effect: pop=0, s_intr=0.
- Mask and gie writes take effect at the edge and are visible to arbitration the next cycle. gie is not changed by entry or return.
- push and pop are never asserted in the same cycle.

## Timing
- Minimum latency: irq rising before edge E0 -> pending set at E0 -> ACK registered at E1 -> push/intr_take high in cycle E1..E2, stack written at E2.
- A request blocked by gie, mask, stk_busy, reti, or a lower-or-equal priority level stays pending indefinitely; it is taken in the first eligible cycle.
- Back-to-back entries are allowed (nesting). A strictly higher-priority source may enter in the cycle after an ACK; at least one IDLE cycle separates consecutive ACKs.
- Maximum nesting depth is NSRC. A source cannot preempt itself.
- reset=0 during ACK: no push occurs at that edge (state, pending, and isr all cleared). Reset has priority over every other input.

## Test plan
- Reset, mask=4'b1111, ei, pulse irq[2] with pc=10'h050 -> pending=4'b0100, then one ACK cycle with push=1, dato=10'h050, vector=10'h3E8; isr=4'b0100 afterward.
- While isr=4'b0100: pulse irq[3] -> no ACK, pending[3] held. Pulse irq[0] -> ACK with vector=10'h3E0, isr=4'b0101.
- reti with isr=4'b0101 -> pop=s_intr=1 that cycle, isr=4'b0100. Second reti -> isr=0, then the held irq[3] is taken (vector 10'h3EC).
- irq[1] edge with gie=0 or mask[1]=0, or stk_busy=1 -> no ACK until enabled or stk_busy is released; exactly one ACK follows.
- reti with isr=0 -> pop=0. irq[0] and irq[1] edges in the same cycle -> source 0 is taken first.
- reset=0 asserted in the ACK cycle -> no stack write follows; all outputs return to their reset values.
